// File: rtl/txd_arbiter_pkg.sv
// Shared serial-line definitions: transmitter state encoding and frame line levels.
// Also used by the receive side so both ends agree on start/stop polarity.
package txd_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WAIT  = 3'd4
  } tx_state_e;

  localparam logic MARKING   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/txd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request after pointer 'last', wrapping.
// Zero latency; no state, the pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin : pick
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    // k = N_REQ revisits 'last' itself, so it is always the lowest priority
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last) + k) % N_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        gnt_idx   = IW'(j);
        gnt_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/txd_arbiter.sv
// Round-robin share of one async txd line among N_REQ dav_/rfd byte producers; grant in one edge,
// frame 10*BIT_CYCLES cycles; rfd[i] drops on capture and producers wait for it to rise again.
module txd_arbiter
  import txd_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_,
  input  logic [N_REQ-1:0]         dav_,
  input  logic [8*N_REQ-1:0]       data,
  output logic [N_REQ-1:0]         rfd,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] gnt
);

  localparam int             IW      = $clog2(N_REQ);
  localparam logic [7:0]     BC_LAST = 8'(BIT_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]  rfd_q, rfd_d;
  logic              busy_q, busy_d;
  logic              txd_q, txd_d;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  arb_oh;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [7:0]        byte_arr [N_REQ];

  logic              cyc_end;
  logic              hs_done;
  logic              closing;
  logic              do_grant;

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign byte_arr[i] = data[8*i +: 8];
  end

  assign req = ~dav_ & rfd_q;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .last    (last_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign cyc_end = (cyc_q == BC_LAST);
  assign hs_done = rfd_q[gnt_q];
  assign closing = !rfd_q[gnt_q] && dav_[gnt_q];

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    rfd_d    = rfd_q;
    busy_d   = busy_q;
    txd_d    = txd_q;
    do_grant = 1'b0;

    // Handshake closure is independent of where the serializer is
    if (closing) begin
      rfd_d[gnt_q] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        txd_d = MARKING;
        if (arb_any) begin
          do_grant = 1'b1;
        end
      end
      START: begin
        if (cyc_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          txd_d   = sh_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      DATA: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = STOP_BIT;
            state_d = STOP;
          end else begin
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      STOP: begin
        if (cyc_end) begin
          // Last stop cycle doubles as the grant slot so frames run back to back
          if (hs_done && arb_any) begin
            do_grant = 1'b1;
          end else if (hs_done) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            busy_d  = 1'b0;
            state_d = WAIT;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      WAIT: begin
        txd_d  = MARKING;
        busy_d = 1'b0;
        if (hs_done || closing) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = MARKING;
        busy_d  = 1'b0;
      end
    endcase

    if (do_grant) begin
      sh_d           = byte_arr[arb_idx];
      rfd_d[arb_idx] = 1'b0;
      last_d         = arb_idx;
      gnt_d          = arb_idx;
      busy_d         = 1'b1;
      txd_d          = START_BIT;
      cyc_d          = '0;
      bit_d          = '0;
      state_d        = START;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      rfd_q   <= '1;
      busy_q  <= 1'b0;
      txd_q   <= MARKING;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rfd_q   <= rfd_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
    end
  end

  // arb_oh is kept for debug probing; the encoded index drives all state
  logic unused_oh;
  assign unused_oh = ^arb_oh;

  assign rfd  = rfd_q;
  assign txd  = txd_q;
  assign busy = busy_q;
  assign gnt  = gnt_q;

endmodule

// File: tb/tb_txd_arbiter.sv
// Directed bench for txd_arbiter: one instance at BIT_CYCLES=1, one at BIT_CYCLES=16.
// Producers are modelled in tick(): release dav_ after an optional hold, optionally re-request.
module tb_txd_arbiter;

  logic        clock;
  logic        reset_;
  logic [3:0]  dav_;
  logic [31:0] data;
  logic [3:0]  rfd;
  logic        txd;
  logic        busy;
  logic [1:0]  gnt;

  logic [3:0]  dav16_;
  logic [31:0] data16;
  logic [3:0]  rfd16;
  logic        txd16;
  logic        busy16;
  logic [1:0]  gnt16;

  int          vec;
  int          errs;
  int          hold_cnt [4];
  bit          rearm [4];
  logic [9:0]  rx;

  txd_arbiter #(.N_REQ(4), .BIT_CYCLES(1)) dut1 (
    .clock (clock), .reset_ (reset_), .dav_ (dav_), .data (data),
    .rfd (rfd), .txd (txd), .busy (busy), .gnt (gnt)
  );

  txd_arbiter #(.N_REQ(4), .BIT_CYCLES(16)) dut16 (
    .clock (clock), .reset_ (reset_), .dav_ (dav16_), .data (data16),
    .rfd (rfd16), .txd (txd16), .busy (busy16), .gnt (gnt16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!rfd[i] && !dav_[i]) begin
        if (hold_cnt[i] == 0) dav_[i] = 1'b1;
        else hold_cnt[i]--;
      end else if (rfd[i] && dav_[i] && rearm[i]) begin
        dav_[i] = 1'b0;
      end
    end
  endtask

  // Grant edge plus nine bit times; optionally raises dav_[inj] during the frame
  task automatic frame(input logic [7:0] b, input logic [1:0] g, input int inj);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    tick();
    check("grant_gnt", 32'(gnt), 32'(g));
    check("grant_rfd_low", 32'(rfd[g]), 0);
    check("start_bit", 32'(txd), 0);
    check("grant_busy", 32'(busy), 1);
    for (int k = 1; k < 10; k++) begin
      tick();
      if (k == 4 && inj >= 0) dav_[inj] = 1'b0;
      check($sformatf("frame_%0h_bit%0d", b, k), 32'(txd), 32'(f[k]));
      check($sformatf("frame_%0h_busy%0d", b, k), 32'(busy), 1);
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      hold_cnt[i] = 0;
      rearm[i] = 1'b0;
    end
    reset_ = 1'b0;
    dav_   = 4'hF;
    data   = '0;
    dav16_ = 4'hF;
    data16 = '0;
    rx     = '0;

    // Reset values
    tick();
    tick();
    check("rst_txd", 32'(txd), 1);
    check("rst_rfd", 32'(rfd), 32'hF);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst16_txd", 32'(txd16), 1);
    reset_ = 1'b1;
    tick();

    // Single byte 0x0D from requester 0
    data    = 32'h0000_000D;
    dav_[0] = 1'b0;
    frame(8'h0D, 2'd0, -1);
    tick();
    check("single_busy_end", 32'(busy), 0);
    check("single_txd_idle", 32'(txd), 1);
    check("single_rfd_back", 32'(rfd), 32'hF);

    // Contention from reset pointer: 0,1,2,3 back to back
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();
    data = 32'h4433_2211;
    dav_ = 4'h0;
    frame(8'h11, 2'd0, -1);
    frame(8'h22, 2'd1, -1);
    frame(8'h33, 2'd2, -1);
    frame(8'h44, 2'd3, -1);
    tick();
    check("contend_busy_end", 32'(busy), 0);

    // Fairness: 1 continuous, 2 requests once during the first frame
    data     = 32'h005A_A500;
    rearm[1] = 1'b1;
    dav_[1]  = 1'b0;
    frame(8'hA5, 2'd1, 2);
    frame(8'h5A, 2'd2, -1);
    rearm[1] = 1'b0;
    frame(8'hA5, 2'd1, -1);
    tick();
    check("fair_busy_end", 32'(busy), 0);

    // Slow release by 3; requester 0 queues behind it with 0xFF held long
    data        = 32'h3C00_00FF;
    hold_cnt[3] = 15;
    hold_cnt[0] = 20;
    dav_[3]     = 1'b0;
    frame(8'h3C, 2'd3, 0);
    for (int c = 10; c <= 15; c++) begin
      tick();
      check($sformatf("wait_txd_%0d", c), 32'(txd), 1);
      check($sformatf("wait_busy_%0d", c), 32'(busy), 0);
      check($sformatf("wait_rfd3_%0d", c), 32'(rfd[3]), 0);
    end
    tick();
    check("wait_rfd3_rise", 32'(rfd), 32'hF);
    check("wait_txd_last", 32'(txd), 1);
    tick();
    check("after_wait_gnt", 32'(gnt), 0);
    check("after_wait_start", 32'(txd), 0);
    check("after_wait_busy", 32'(busy), 1);

    // Reset during data bit 4 of 0xFF
    for (int c = 0; c < 5; c++) tick();
    check("pre_rst_rfd0", 32'(rfd[0]), 0);
    #2;
    reset_ = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 1);
    check("midrst_rfd", 32'(rfd), 32'hF);
    check("midrst_busy", 32'(busy), 0);
    dav_ = 4'hF;
    for (int i = 0; i < 4; i++) hold_cnt[i] = 0;
    tick();
    reset_ = 1'b1;
    data = 32'h0000_7700;
    dav_ = 4'b1100;
    tick();
    check("postrst_gnt", 32'(gnt), 0);
    check("postrst_txd", 32'(txd), 0);
    check("postrst_rfd", 32'(rfd), 32'hE);
    reset_ = 1'b0;
    tick();
    dav_ = 4'hF;
    reset_ = 1'b1;
    tick();

    // BIT_CYCLES=16: 0x9C sampled mid-bit
    data16 = 32'h0000_009C;
    dav16_ = 4'b1110;
    tick();
    check("bc16_start", 32'(txd16), 0);
    check("bc16_rfd_low", 32'(rfd16[0]), 0);
    check("bc16_busy", 32'(busy16), 1);
    dav16_ = 4'hF;
    for (int c = 1; c < 160; c++) begin
      tick();
      if (c % 16 == 8) rx[c / 16] = txd16;
      if (c == 159) check("bc16_busy_159", 32'(busy16), 1);
    end
    tick();
    check("bc16_busy_160", 32'(busy16), 0);
    check("bc16_startbit", 32'(rx[0]), 0);
    check("bc16_byte", 32'(rx[8:1]), 32'h9C);
    check("bc16_stopbit", 32'(rx[9]), 1);
    check("bc16_rfd_back", 32'(rfd16), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
